// File: rtl/rf_req_fifo_pkg.sv
// Shared widths, request-entry layout and issue-state encoding for the
// register-file operand-read request queue.
package rf_req_fifo_pkg;

  localparam int BANK_W = 2;
  localparam int ROW_W  = 3;
  localparam int TAG_W  = 3;

  typedef struct packed {
    logic              v1;
    logic [BANK_W-1:0] b1;
    logic [ROW_W-1:0]  r1;
    logic [TAG_W-1:0]  t1;
    logic              v2;
    logic [BANK_W-1:0] b2;
    logic [ROW_W-1:0]  r2;
    logic [TAG_W-1:0]  t2;
    logic              same;
  } req_entry_t;

  // Encoding is {p1, p2}, so the state register doubles as the pending bits.
  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_SRC2 = 2'b01,
    ST_SRC1 = 2'b10,
    ST_BOTH = 2'b11
  } issue_state_t;

  function automatic issue_state_t head_state(input req_entry_t e);
    return issue_state_t'({e.v1, e.v2});
  endfunction

endpackage

// File: rtl/rf_req_issue.sv
// Combinational issue decision for the queue head: which sources read this
// cycle, and whether the head retires.
module rf_req_issue
  import rf_req_fifo_pkg::*;
(
  input  req_entry_t        head,
  input  logic              active,
  input  logic              p1,
  input  logic              p2,
  input  logic              write_valid,
  input  logic [BANK_W-1:0] write_bank,
  output logic              iss1,
  output logic              iss2,
  output logic              pop
);

  logic blk1;
  logic blk2;
  logic unused_fields;

  assign unused_fields = ^{head.r1, head.t1, head.r2, head.t2};

  always_comb begin
    blk1 = write_valid && (write_bank == head.b1);
    blk2 = write_valid && (write_bank == head.b2);
    iss1 = active && p1 && head.v1 && !blk1;
    // A same-bank pair never reads src2 while src1 is still outstanding.
    iss2 = active && p2 && head.v2 && !blk2 && !(head.same && p1);
    pop  = active && !(p1 && !iss1) && !(p2 && !iss2);
  end

endmodule

// File: rtl/rf_req_fifo.sv
// Operand-read request FIFO: buffers mapped instructions and issues registered
// per-bank register-file reads for the head entry.
module rf_req_fifo
  import rf_req_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NBANK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Valid_RAU_ReqFIFO,
  input  logic                    Src1_Valid,
  input  logic                    Src2_Valid,
  input  logic [BANK_W-1:0]       Src1_Phy_Bank_ID,
  input  logic [BANK_W-1:0]       Src2_Phy_Bank_ID,
  input  logic [ROW_W-1:0]        Src1_Phy_Row_ID,
  input  logic [ROW_W-1:0]        Src2_Phy_Row_ID,
  input  logic [TAG_W-1:0]        Src1_OCID_RAU_OC,
  input  logic [TAG_W-1:0]        Src2_OCID_RAU_OC,
  input  logic                    ReqFIFO_2op_EN,
  input  logic                    WriteValid,
  input  logic [BANK_W-1:0]       WriteBank,
  output logic                    Full_ReqFIFO_RAU,
  output logic [$clog2(DEPTH):0]  Count_ReqFIFO,
  output logic [NBANK-1:0]        RdEn_ReqFIFO_RF,
  output logic [NBANK*ROW_W-1:0]  RdRow_ReqFIFO_RF,
  output logic [NBANK*TAG_W-1:0]  RdTag_ReqFIFO_OC
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  req_entry_t         mem [DEPTH];
  req_entry_t         in_entry;
  req_entry_t         head;
  req_entry_t         next_head;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  issue_state_t       state;
  issue_state_t       state_nxt;
  logic               push;
  logic               pop;
  logic               active;
  logic               iss1;
  logic               iss2;
  logic [NBANK-1:0]       rden_nxt;
  logic [NBANK*ROW_W-1:0] row_nxt;
  logic [NBANK*TAG_W-1:0] tag_nxt;

  always_comb begin
    in_entry = '{v1: Src1_Valid, b1: Src1_Phy_Bank_ID, r1: Src1_Phy_Row_ID,
                 t1: Src1_OCID_RAU_OC, v2: Src2_Valid, b2: Src2_Phy_Bank_ID,
                 r2: Src2_Phy_Row_ID, t2: Src2_OCID_RAU_OC, same: ReqFIFO_2op_EN};
  end

  // Upstream handshake: an instruction transfers on any cycle where
  // Valid_RAU_ReqFIFO is high and Full_ReqFIFO_RAU is low; otherwise upstream holds it.
  assign Full_ReqFIFO_RAU = (count == FULL_CNT);
  assign Count_ReqFIFO    = count;
  assign push      = Valid_RAU_ReqFIFO && !Full_ReqFIFO_RAU && (Src1_Valid || Src2_Valid);
  assign active    = (count != '0);
  assign head      = mem[rd_ptr];
  assign next_head = mem[rd_ptr + PW'(1)];

  rf_req_issue u_issue (
    .head        (head),
    .active      (active),
    .p1          (state[1]),
    .p2          (state[0]),
    .write_valid (WriteValid),
    .write_bank  (WriteBank),
    .iss1        (iss1),
    .iss2        (iss2),
    .pop         (pop)
  );

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= ST_NONE;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Pending bits reload whenever a different entry becomes head; with one
  // entry left, a simultaneous push is the entry that becomes head.
  always_comb begin
    state_nxt = state;
    if (pop) begin
      if (count > CW'(1)) state_nxt = head_state(next_head);
      else if (push)      state_nxt = head_state(in_entry);
      else                state_nxt = ST_NONE;
    end else if (!active) begin
      state_nxt = push ? head_state(in_entry) : ST_NONE;
    end else begin
      state_nxt = issue_state_t'({state[1] && !iss1, state[0] && !iss2});
    end
  end

  always_comb begin
    rden_nxt = '0;
    row_nxt  = '0;
    tag_nxt  = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (iss1 && head.b1 == BANK_W'(b)) begin
        rden_nxt[b]               = 1'b1;
        row_nxt[b*ROW_W +: ROW_W] = head.r1;
        tag_nxt[b*TAG_W +: TAG_W] = head.t1;
      end else if (iss2 && head.b2 == BANK_W'(b)) begin
        rden_nxt[b]               = 1'b1;
        row_nxt[b*ROW_W +: ROW_W] = head.r2;
        tag_nxt[b*TAG_W +: TAG_W] = head.t2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RdEn_ReqFIFO_RF  <= '0;
      RdRow_ReqFIFO_RF <= '0;
      RdTag_ReqFIFO_OC <= '0;
    end else begin
      RdEn_ReqFIFO_RF  <= rden_nxt;
      RdRow_ReqFIFO_RF <= row_nxt;
      RdTag_ReqFIFO_OC <= tag_nxt;
    end
  end

endmodule

// File: tb/tb_rf_req_fifo.sv
// Directed bench for rf_req_fifo: stimulus pushes expected reads into a queue,
// a monitor pops and compares every bank read the DUT presents.
module tb_rf_req_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid, s1v, s2v, two_op, wv;
  logic [1:0]  b1, b2, wb;
  logic [2:0]  r1, r2, t1, t2;
  logic        full;
  logic [2:0]  count;
  logic [3:0]  rden;
  logic [11:0] rdrow, rdtag;

  logic [7:0]  exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        done     = 1'b0;

  rf_req_fifo #(.DEPTH(4), .NBANK(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .Valid_RAU_ReqFIFO (valid),
    .Src1_Valid        (s1v),
    .Src2_Valid        (s2v),
    .Src1_Phy_Bank_ID  (b1),
    .Src2_Phy_Bank_ID  (b2),
    .Src1_Phy_Row_ID   (r1),
    .Src2_Phy_Row_ID   (r2),
    .Src1_OCID_RAU_OC  (t1),
    .Src2_OCID_RAU_OC  (t2),
    .ReqFIFO_2op_EN    (two_op),
    .WriteValid        (wv),
    .WriteBank         (wb),
    .Full_ReqFIFO_RAU  (full),
    .Count_ReqFIFO     (count),
    .RdEn_ReqFIFO_RF   (rden),
    .RdRow_ReqFIFO_RF  (rdrow),
    .RdTag_ReqFIFO_OC  (rdtag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input logic [1:0] b, input logic [2:0] r, input logic [2:0] t);
    exp_q.push_back({b, r, t});
  endtask

  task automatic drive_req(input logic v1_i, input logic [1:0] b1_i, input logic [2:0] r1_i,
                           input logic [2:0] t1_i, input logic v2_i, input logic [1:0] b2_i,
                           input logic [2:0] r2_i, input logic [2:0] t2_i, input logic same_i);
    s1v = v1_i; b1 = b1_i; r1 = r1_i; t1 = t1_i;
    s2v = v2_i; b2 = b2_i; r2 = r2_i; t2 = t2_i;
    two_op = same_i;
    valid  = 1'b1;
  endtask

  // Holds the presented instruction until a cycle with Full low has passed an edge.
  task automatic wait_accept();
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      acc = !full;
      step();
      guard++;
    end
    chk("push_accept", acc, 1);
  endtask

  task automatic monitor();
    logic [7:0] got;
    logic [7:0] e;
    while (!done) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
        got = {2'(b), rdrow[3*b +: 3], rdtag[3*b +: 3]};
        if (rden[b]) begin
          if (exp_q.size() == 0) begin
            chk("rd_unexpected", {24'd0, got}, 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            chk("rd_bank_row_tag", {24'd0, got}, {24'd0, e});
          end
        end else begin
          chk("idle_bank_zero", {26'd0, got[5:0]}, 0);
        end
      end
    end
  endtask

  task automatic stimulus();
    // Different-bank pair, no writes.
    expect_rd(2'd0, 3'd2, 3'd0);
    expect_rd(2'd3, 3'd5, 3'd1);
    drive_req(1, 2'd0, 3'd2, 3'd0, 1, 2'd3, 3'd5, 3'd1, 0);
    wait_accept();
    valid = 1'b0;
    chk("t1_count_after_push", count, 1);
    step();
    chk("t1_rden", rden, 4'b1001);
    chk("t1_count_popped", count, 0);
    step();
    chk("t1_rden_clear", rden, 0);

    // Same-bank pair serialised src1 then src2.
    expect_rd(2'd2, 3'd1, 3'd2);
    expect_rd(2'd2, 3'd4, 3'd3);
    drive_req(1, 2'd2, 3'd1, 3'd2, 1, 2'd2, 3'd4, 3'd3, 1);
    wait_accept();
    valid = 1'b0;
    step();
    chk("t2_rden_src1", rden, 4'b0100);
    chk("t2_row_src1", rdrow[8:6], 1);
    chk("t2_count_held", count, 1);
    step();
    chk("t2_rden_src2", rden, 4'b0100);
    chk("t2_row_src2", rdrow[8:6], 4);
    chk("t2_count_popped", count, 0);
    step();
    chk("t2_rden_clear", rden, 0);

    // src1 bank blocked by CDB write for two head cycles.
    expect_rd(2'd0, 3'd7, 3'd5);
    expect_rd(2'd1, 3'd6, 3'd4);
    wv = 1'b1; wb = 2'd1;
    drive_req(1, 2'd1, 3'd6, 3'd4, 1, 2'd0, 3'd7, 3'd5, 0);
    wait_accept();
    valid = 1'b0;
    step();
    chk("t3_rden_src2_first", rden, 4'b0001);
    chk("t3_count_held", count, 1);
    step();
    chk("t3_rden_blocked", rden, 0);
    wv = 1'b0;
    step();
    chk("t3_rden_src1_late", rden, 4'b0010);
    chk("t3_count_popped", count, 0);

    // Fill to full with bank 3 blocked, then a held push and drain in order.
    wv = 1'b1; wb = 2'd3;
    for (int i = 0; i < 6; i++) begin
      expect_rd(2'd3, 3'(i), 3'(i));
      expect_rd(2'd3, 3'(i + 2), 3'(7 - i));
      drive_req(1, 2'd3, 3'(i), 3'(i), 1, 2'd3, 3'(i + 2), 3'(7 - i), 1);
      if (i == 4) begin
        step();
        step();
        chk("t4_count_push_ignored", count, 4);
        chk("t4_full_held", full, 1);
        wv = 1'b0;
      end
      wait_accept();
      if (i == 3) begin
        chk("t4_full", full, 1);
        chk("t4_count_full", count, 4);
      end
    end
    valid = 1'b0;
    repeat (16) step();
    chk("t4_count_drained", count, 0);
    chk("t4_full_drained", full, 0);

    // Instruction with no valid source is dropped.
    drive_req(0, 2'd1, 3'd1, 3'd1, 0, 2'd2, 3'd2, 3'd2, 0);
    step();
    valid = 1'b0;
    chk("t5_count_no_src", count, 0);
    step();
    chk("t5_count_still_zero", count, 0);
    chk("t5_rden_none", rden, 0);

    // Reset while a same-bank head waits for src2.
    expect_rd(2'd2, 3'd3, 3'd1);
    drive_req(1, 2'd2, 3'd3, 3'd1, 1, 2'd2, 3'd6, 3'd2, 1);
    wait_accept();
    valid = 1'b0;
    step();
    chk("t6_rden_src1", rden, 4'b0100);
    wv = 1'b1; wb = 2'd2;
    step();
    chk("t6_rden_blocked", rden, 0);
    chk("t6_count_waiting", count, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_count", count, 0);
    chk("t6_async_full", full, 0);
    chk("t6_async_rden", rden, 0);
    chk("t6_async_row", rdrow, 0);
    chk("t6_async_tag", rdtag, 0);
    step();
    rst = 1'b1;
    wv  = 1'b0;
    repeat (5) step();
    chk("t6_count_after_release", count, 0);
    chk("t6_rden_after_release", rden, 0);
  endtask

  initial begin
    valid = 1'b0; s1v = 1'b0; s2v = 1'b0; two_op = 1'b0; wv = 1'b0;
    b1 = '0; b2 = '0; wb = '0; r1 = '0; r2 = '0; t1 = '0; t2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_full", full, 0);
    chk("reset_count", count, 0);
    chk("reset_rden", rden, 0);
    chk("reset_row", rdrow, 0);
    chk("reset_tag", rdtag, 0);
    rst = 1'b1;
    step();
    fork
      monitor();
      begin
        stimulus();
        done = 1'b1;
      end
    join
    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
